// File: rtl/demux_pkg.sv
// Shared types, channel count and round-robin search for the packet demux.
package demux_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // First enabled channel searching base+1, base+2, base+3, base.
  // Descending loop so the nearest candidate is the last one written.
  // With no channel enabled the base is returned unchanged.
  function automatic logic [1:0] rr_next(input logic [1:0]        base,
                                         input logic [NUM_CH-1:0] en);
    logic [1:0] c;
    rr_next = base;
    for (int i = NUM_CH; i >= 1; i--) begin
      c = base + 2'(i);
      if (en[c]) rr_next = c;
    end
  endfunction

endpackage

// File: rtl/demux_rr_next.sv
// Combinational next-enabled-channel lookup used at packet boundaries.
module demux_rr_next
  import demux_pkg::*;
(
  input  logic [1:0]        sel,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [1:0]        nxt
);

  assign nxt = rr_next(sel, ch_en);

endmodule

// File: rtl/demux_rr_ctrl.sv
// Packet-granular round-robin 1-to-4 demux with a one-entry output register.
// A whole packet of PKT_LEN words goes to channel sel; sel moves only once
// the packet's last word has left the register.
module demux_rr_ctrl
  import demux_pkg::*;
#(
  parameter int DW      = 8,
  parameter int PKT_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  output logic [NUM_CH-1:0] out_valid,
  output logic [DW-1:0]     out_data,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [1:0]        sel,
  output logic              pkt_done
);

  localparam logic [7:0] LAST = 8'(PKT_LEN - 1);

  state_t          state_q, state_d;
  logic [1:0]      sel_q, sel_d, base, nxt;
  logic            vld_q, last_q;
  logic [7:0]      cnt_q;
  logic [DW-1:0]   data_q;
  logic            ifire, ofire, go_idle;

  // From IDLE the search starts below channel 0 so the lowest enabled
  // channel wins; otherwise it continues from the current owner.
  assign base = (state_q == IDLE) ? 2'd3 : sel_q;

  demux_rr_next u_next (
    .sel   (base),
    .ch_en (ch_en),
    .nxt   (nxt)
  );

  assign ofire     = vld_q && out_ready[sel_q];
  assign ifire     = in_valid && in_ready;
  // Boundary with nothing in flight and every channel disabled.
  assign go_idle   = (state_q == ACTIVE) && (cnt_q == '0) && !vld_q && (ch_en == '0);
  assign pkt_done  = ofire && last_q;
  assign out_valid = vld_q ? (4'b0001 << sel_q) : '0;
  assign out_data  = data_q;
  assign sel       = sel_q;

  // Next state, next owner and input handshake.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (ch_en != '0) begin
          state_d = ACTIVE;
          sel_d   = nxt;
        end
      end
      ACTIVE: begin
        // Last word of a packet blocks input until it drains, so the next
        // packet never lands under the old owner.
        in_ready = !last_q && (!vld_q || out_ready[sel_q]) && !go_idle;
        if (go_idle)
          state_d = IDLE;
        else if (pkt_done && (ch_en != '0))
          sel_d = nxt;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Output register and in-packet word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      cnt_q  <= '0;
      data_q <= '0;
    end else if (ifire) begin
      vld_q  <= 1'b1;
      data_q <= in_data;
      last_q <= (cnt_q == LAST);
      cnt_q  <= (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
    end else if (ofire) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demux_rr_ctrl.sv
// Directed bench for demux_rr_ctrl (DW=8, PKT_LEN=4).
module tb_demux_rr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ch_en;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] out_valid;
  logic [7:0] out_data;
  logic [3:0] out_ready;
  logic [1:0] sel;
  logic       pkt_done;

  int n_chk  = 0;
  int n_fail = 0;

  int         log_ch[$];
  logic [7:0] log_d[$];
  int         done_q[$];
  bit         seen[4];

  demux_rr_ctrl #(.DW(8), .PKT_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .pkt_done  (pkt_done)
  );

  always #5 clk = ~clk;

  // Record every downstream transfer mid-cycle (it completes at the next posedge).
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k]) seen[k] = 1'b1;
        if (out_valid[k] && out_ready[k]) begin
          log_ch.push_back(k);
          log_d.push_back(out_data);
        end
      end
      if (pkt_done) done_q.push_back(log_ch.size() - 1);
    end
  end

  task automatic clear_logs();
    log_ch.delete();
    log_d.delete();
    done_q.delete();
    for (int k = 0; k < 4; k++) seen[k] = 1'b0;
  endtask

  task automatic do_reset(input logic [3:0] mask);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    ch_en     = mask;
    out_ready = 4'b1111;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_%h: in_ready=%b, required 1 within 40 cycles", d, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    ch_en     = 4'b1111;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    out_ready = 4'b1111;
    clear_logs();
    @(negedge clk);
    n_chk++; if (in_ready  !== 1'b0)    begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_chk++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0000", out_valid); end
    n_chk++; if (out_data  !== 8'h00)   begin n_fail++; $display("FAIL rst_out_data: got %h want 00", out_data); end
    n_chk++; if (sel       !== 2'd0)    begin n_fail++; $display("FAIL rst_sel: got %0d want 0", sel); end
    n_chk++; if (pkt_done  !== 1'b0)    begin n_fail++; $display("FAIL rst_pkt_done: got %b want 0", pkt_done); end
    #2 rst_n = 1'b1;
    #1;
    n_chk++; if (in_ready  !== 1'b0)    begin n_fail++; $display("FAIL rel_in_ready: got %b want 0", in_ready); end
    n_chk++; if (pkt_done  !== 1'b0)    begin n_fail++; $display("FAIL rel_pkt_done: got %b want 0", pkt_done); end
    @(negedge clk);
    n_chk++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL rel_out_valid: got %b want 0000", out_valid); end
    n_chk++; if (in_ready  !== 1'b1)    begin n_fail++; $display("FAIL rel_active: in_ready got %b want 1", in_ready); end
    in_valid = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_rr_basic();
    logic [7:0] d;
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      d = 8'h10 + 8'(i);
      send(d);
    end
    idle_cycles(3);
    n_chk++; if (log_d.size() !== 8) begin n_fail++; $display("FAIL rr_count: got %0d words want 8", log_d.size()); end
    for (int i = 0; i < 8 && i < log_d.size(); i++) begin
      d = 8'h10 + 8'(i);
      n_chk++;
      if (log_d[i] !== d || log_ch[i] !== i / 4) begin
        n_fail++;
        $display("FAIL rr_word%0d: got %h on ch%0d want %h on ch%0d", i, log_d[i], log_ch[i], d, i / 4);
      end
    end
    n_chk++; if (done_q.size() !== 2) begin n_fail++; $display("FAIL rr_pkt_done: got %0d pulses want 2", done_q.size()); end
    n_chk++; if (sel !== 2'd2) begin n_fail++; $display("FAIL rr_sel: got %0d want 2", sel); end
  endtask

  task automatic test_mask();
    logic [7:0] d;
    int         ech[3];
    ech = '{0, 2, 0};
    do_reset(4'b0101);
    for (int i = 0; i < 12; i++) begin
      d = 8'h20 + 8'(i);
      send(d);
    end
    idle_cycles(3);
    n_chk++; if (log_d.size() !== 12) begin n_fail++; $display("FAIL mask_count: got %0d words want 12", log_d.size()); end
    for (int i = 0; i < 12 && i < log_d.size(); i++) begin
      d = 8'h20 + 8'(i);
      n_chk++;
      if (log_d[i] !== d || log_ch[i] !== ech[i / 4]) begin
        n_fail++;
        $display("FAIL mask_word%0d: got %h on ch%0d want %h on ch%0d", i, log_d[i], log_ch[i], d, ech[i / 4]);
      end
    end
    n_chk++; if (seen[1] || seen[3]) begin n_fail++; $display("FAIL mask_disabled: ch1 valid=%b ch3 valid=%b want 0 0", seen[1], seen[3]); end
    n_chk++; if (done_q.size() !== 3) begin n_fail++; $display("FAIL mask_pkt_done: got %0d pulses want 3", done_q.size()); end
  endtask

  task automatic test_stall();
    logic [7:0] exp_d[4];
    exp_d = '{8'hA5, 8'hA6, 8'hA7, 8'hA8};
    do_reset(4'b0001);
    out_ready = 4'b1110;
    send(8'hA5);
    in_valid = 1'b1;
    in_data  = 8'hA6;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++; if (out_data  !== 8'hA5)   begin n_fail++; $display("FAIL stall_data_c%0d: got %h want a5", c, out_data); end
      n_chk++; if (out_valid !== 4'b0001) begin n_fail++; $display("FAIL stall_valid_c%0d: got %b want 0001", c, out_valid); end
      n_chk++; if (in_ready  !== 1'b0)    begin n_fail++; $display("FAIL stall_in_ready_c%0d: got %b want 0", c, in_ready); end
      n_chk++; if (pkt_done  !== 1'b0)    begin n_fail++; $display("FAIL stall_pkt_done_c%0d: got %b want 0", c, pkt_done); end
    end
    @(posedge clk); #1;
    out_ready = 4'b1111;
    send(8'hA6);
    send(8'hA7);
    send(8'hA8);
    idle_cycles(3);
    n_chk++; if (log_d.size() !== 4) begin n_fail++; $display("FAIL stall_count: got %0d words want 4", log_d.size()); end
    for (int i = 0; i < 4 && i < log_d.size(); i++) begin
      n_chk++;
      if (log_d[i] !== exp_d[i] || log_ch[i] !== 0) begin
        n_fail++;
        $display("FAIL stall_word%0d: got %h on ch%0d want %h on ch0", i, log_d[i], log_ch[i], exp_d[i]);
      end
    end
    n_chk++;
    if (done_q.size() !== 1 || done_q[0] !== 3) begin
      n_fail++;
      $display("FAIL stall_boundary: got %0d pulses, first at word %0d; want 1 at word 3", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
    end
  endtask

  task automatic test_en_change();
    logic [7:0] d;
    do_reset(4'b0011);
    send(8'h30);
    send(8'h31);
    ch_en = 4'b1000;
    for (int i = 2; i < 8; i++) begin
      d = 8'h30 + 8'(i);
      send(d);
    end
    idle_cycles(3);
    n_chk++; if (log_d.size() !== 8) begin n_fail++; $display("FAIL en_count: got %0d words want 8", log_d.size()); end
    for (int i = 0; i < 8 && i < log_d.size(); i++) begin
      d = 8'h30 + 8'(i);
      n_chk++;
      if (log_d[i] !== d || log_ch[i] !== ((i < 4) ? 0 : 3)) begin
        n_fail++;
        $display("FAIL en_word%0d: got %h on ch%0d want %h on ch%0d", i, log_d[i], log_ch[i], d, (i < 4) ? 0 : 3);
      end
    end
    n_chk++; if (sel !== 2'd3) begin n_fail++; $display("FAIL en_sel_hold: got %0d want 3", sel); end
  endtask

  task automatic test_idle();
    logic [7:0] d;
    do_reset(4'b0000);
    in_valid = 1'b1;
    in_data  = 8'h40;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++; if (in_ready  !== 1'b0)    begin n_fail++; $display("FAIL idle_in_ready_c%0d: got %b want 0", c, in_ready); end
      n_chk++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL idle_out_valid_c%0d: got %b want 0000", c, out_valid); end
    end
    @(posedge clk); #1;
    ch_en = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      d = 8'h40 + 8'(i);
      send(d);
    end
    idle_cycles(3);
    n_chk++; if (log_d.size() !== 4) begin n_fail++; $display("FAIL idle_count: got %0d words want 4", log_d.size()); end
    for (int i = 0; i < 4 && i < log_d.size(); i++) begin
      d = 8'h40 + 8'(i);
      n_chk++;
      if (log_d[i] !== d || log_ch[i] !== 1) begin
        n_fail++;
        $display("FAIL idle_word%0d: got %h on ch%0d want %h on ch1", i, log_d[i], log_ch[i], d);
      end
    end
    n_chk++; if (sel !== 2'd1) begin n_fail++; $display("FAIL idle_sel: got %0d want 1", sel); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    do_reset(4'b1111);
    send(8'h50);
    @(posedge clk); #1;
    out_ready = 4'b0000;
    send(8'h51);
    @(negedge clk);
    n_chk++;
    if (out_valid !== 4'b0001 || out_data !== 8'h51) begin
      n_fail++;
      $display("FAIL mid_hold: got valid=%b data=%h want 0001 51", out_valid, out_data);
    end
    #2;
    rst_n = 1'b0;
    ch_en = 4'b1100;
    #1;
    n_chk++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0000", out_valid); end
    n_chk++; if (out_data  !== 8'h00)   begin n_fail++; $display("FAIL mid_rst_data: got %h want 00", out_data); end
    n_chk++; if (in_ready  !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready); end
    n_chk++; if (sel       !== 2'd0)    begin n_fail++; $display("FAIL mid_rst_sel: got %0d want 0", sel); end
    n_chk++; if (pkt_done  !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_pkt_done: got %b want 0", pkt_done); end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 4'b1111;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      d = 8'h60 + 8'(i);
      send(d);
    end
    idle_cycles(3);
    n_chk++; if (log_d.size() !== 4) begin n_fail++; $display("FAIL mid_count: got %0d words want 4", log_d.size()); end
    for (int i = 0; i < 4 && i < log_d.size(); i++) begin
      d = 8'h60 + 8'(i);
      n_chk++;
      if (log_d[i] !== d || log_ch[i] !== 2) begin
        n_fail++;
        $display("FAIL mid_word%0d: got %h on ch%0d want %h on ch2", i, log_d[i], log_ch[i], d);
      end
    end
    n_chk++;
    if (done_q.size() !== 1 || done_q[0] !== 3) begin
      n_fail++;
      $display("FAIL mid_boundary: got %0d pulses, first at word %0d; want 1 at word 3", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_rr_basic();
    test_mask();
    test_stall();
    test_en_change();
    test_idle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
